// File: rtl/data_memory_arbiter.sv
// Two-port arbiter for a single-ported data memory. Port A (CPU) and port B (loader/debug)
// share one memory; each access takes one ACCESS cycle driven entirely from registers.
module data_memory_arbiter #(
  parameter bit ROUND_ROBIN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        a_req,
  input  logic        a_we,
  input  logic [31:0] a_addr,
  input  logic [31:0] a_wdata,
  output logic        a_gnt,
  output logic        a_rvalid,
  output logic [31:0] a_rdata,

  input  logic        b_req,
  input  logic        b_we,
  input  logic [31:0] b_addr,
  input  logic [31:0] b_wdata,
  output logic        b_gnt,
  output logic        b_rvalid,
  output logic [31:0] b_rdata,

  output logic        mem_write_enable,
  output logic        mem_read_enable,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,

  output logic        busy
);

  typedef enum logic {StIdle, StAccess} state_e;

  state_e state_q;
  logic   last_b_q;  // 1: port B held the most recent grant
  logic   win_b_q;   // port owning the access in flight
  logic   pick_b;

  always_comb begin
    pick_b = 1'b0;
    if (a_req && b_req) begin
      pick_b = ROUND_ROBIN ? ~last_b_q : 1'b0;
    end else begin
      pick_b = b_req;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q          <= StIdle;
      last_b_q         <= 1'b1;
      win_b_q          <= 1'b0;
      a_gnt            <= 1'b0;
      b_gnt            <= 1'b0;
      a_rvalid         <= 1'b0;
      b_rvalid         <= 1'b0;
      a_rdata          <= '0;
      b_rdata          <= '0;
      mem_write_enable <= 1'b0;
      mem_read_enable  <= 1'b0;
      mem_addr         <= '0;
      mem_wdata        <= '0;
      busy             <= 1'b0;
    end else begin
      a_gnt    <= 1'b0;
      b_gnt    <= 1'b0;
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (a_req || b_req) begin
            state_q          <= StAccess;
            busy             <= 1'b1;
            win_b_q          <= pick_b;
            last_b_q         <= pick_b;
            a_gnt            <= ~pick_b;
            b_gnt            <= pick_b;
            mem_write_enable <= pick_b ? b_we : a_we;
            mem_read_enable  <= pick_b ? ~b_we : ~a_we;
            mem_addr         <= pick_b ? b_addr : a_addr;
            mem_wdata        <= pick_b ? b_wdata : a_wdata;
          end
        end
        StAccess: begin
          state_q          <= StIdle;
          busy             <= 1'b0;
          mem_write_enable <= 1'b0;
          mem_read_enable  <= 1'b0;
          if (mem_read_enable) begin
            if (win_b_q) begin
              b_rdata  <= mem_rdata;
              b_rvalid <= 1'b1;
            end else begin
              a_rdata  <= mem_rdata;
              a_rvalid <= 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Bench for data_memory_arbiter: transaction-scheduling reference model with a small memory,
// directed scenarios plus random traffic, and a fixed-priority instance.
`timescale 1ns/100ps
module tb_data_memory_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_req, a_we, b_req, b_we;
  logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
  logic        a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [31:0] a_rdata, b_rdata;
  logic        mem_write_enable, mem_read_enable, busy;
  logic [31:0] mem_addr, mem_wdata;
  wire  [31:0] mem_rdata;

  logic        fp_a_req, fp_b_req;
  logic        fp_a_gnt, fp_a_rvalid, fp_b_gnt, fp_b_rvalid;
  logic [31:0] fp_a_rdata, fp_b_rdata, fp_mem_addr, fp_mem_wdata;
  logic        fp_mem_we, fp_mem_re, fp_busy;

  logic [31:0] mem [16];
  logic        tb_init;

  always #5 clk = ~clk;

  // Memory writes on the negedge inside ACCESS; reads are combinational.
  always @(negedge clk) begin
    if (tb_init) begin
      for (int i = 0; i < 16; i++) mem[i] <= (i == 5) ? 32'h1E13_0000 : 32'h0;
    end else if (mem_write_enable) begin
      mem[mem_addr[3:0]] <= mem_wdata;
    end
  end
  assign mem_rdata = mem_read_enable ? mem[mem_addr[3:0]] : 'z;

  data_memory_arbiter #(.ROUND_ROBIN(1'b1)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .mem_write_enable(mem_write_enable), .mem_read_enable(mem_read_enable),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  data_memory_arbiter #(.ROUND_ROBIN(1'b0)) dut_fp (
    .clk(clk), .reset(reset),
    .a_req(fp_a_req), .a_we(1'b1), .a_addr(32'h0), .a_wdata(32'h0),
    .a_gnt(fp_a_gnt), .a_rvalid(fp_a_rvalid), .a_rdata(fp_a_rdata),
    .b_req(fp_b_req), .b_we(1'b1), .b_addr(32'h1), .b_wdata(32'h0),
    .b_gnt(fp_b_gnt), .b_rvalid(fp_b_rvalid), .b_rdata(fp_b_rdata),
    .mem_write_enable(fp_mem_we), .mem_read_enable(fp_mem_re),
    .mem_addr(fp_mem_addr), .mem_wdata(fp_mem_wdata), .mem_rdata(32'h0),
    .busy(fp_busy)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: which edge the arbiter is free again, who won last, pending read data.
  logic [31:0] mmem [16];
  int          cyc;
  int          free_at;
  bit          last_was_b;
  bit          pend;
  bit          pend_b;
  int          pend_cyc;
  logic [31:0] pend_data;
  logic [31:0] e_ard, e_brd, e_maddr, e_mwd;

  task automatic model_reset();
    pend       = 1'b0;
    last_was_b = 1'b1;
    free_at    = cyc;
    e_ard      = '0;
    e_brd      = '0;
    e_maddr    = '0;
    e_mwd      = '0;
  endtask

  task automatic step(input bit ar, input bit aw, input logic [31:0] aa, input logic [31:0] ad,
                      input bit br, input bit bw, input logic [31:0] ba, input logic [31:0] bd);
    bit e_ag, e_bg, e_arv, e_brv, e_busy, e_we, e_re, wb, w_we;
    logic [31:0] w_addr, w_wd;
    @(negedge clk);
    a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
    b_req = br; b_we = bw; b_addr = ba; b_wdata = bd;
    @(posedge clk);
    #1;
    e_ag = 0; e_bg = 0; e_arv = 0; e_brv = 0; e_busy = 0; e_we = 0; e_re = 0;
    if (pend && pend_cyc == cyc) begin
      if (pend_b) begin e_brv = 1; e_brd = pend_data; end
      else begin e_arv = 1; e_ard = pend_data; end
      pend = 0;
    end
    if (cyc >= free_at && (ar || br)) begin
      wb = (ar && br) ? !last_was_b : br;
      w_we   = wb ? bw : aw;
      w_addr = wb ? ba : aa;
      w_wd   = wb ? bd : ad;
      e_ag = !wb; e_bg = wb; e_busy = 1; e_we = w_we; e_re = !w_we;
      e_maddr = w_addr; e_mwd = w_wd;
      if (w_we) mmem[w_addr[3:0]] = w_wd;
      else begin
        pend = 1; pend_b = wb; pend_cyc = cyc + 1; pend_data = mmem[w_addr[3:0]];
      end
      free_at    = cyc + 2;
      last_was_b = wb;
    end
    check_eq("a_gnt", 32'(a_gnt), 32'(e_ag));
    check_eq("b_gnt", 32'(b_gnt), 32'(e_bg));
    check_eq("a_rvalid", 32'(a_rvalid), 32'(e_arv));
    check_eq("b_rvalid", 32'(b_rvalid), 32'(e_brv));
    check_eq("a_rdata", a_rdata, e_ard);
    check_eq("b_rdata", b_rdata, e_brd);
    check_eq("busy", 32'(busy), 32'(e_busy));
    check_eq("mem_we", 32'(mem_write_enable), 32'(e_we));
    check_eq("mem_re", 32'(mem_read_enable), 32'(e_re));
    check_eq("mem_addr", mem_addr, e_maddr);
    check_eq("mem_wdata", mem_wdata, e_mwd);
    cyc++;
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
  endtask

  initial begin
    tb_init = 1'b1;
    reset   = 1'b0;
    a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
    b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
    fp_a_req = 0; fp_b_req = 0;
    for (int i = 0; i < 16; i++) mmem[i] = (i == 5) ? 32'h1E13_0000 : 32'h0;
    cyc = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    check_eq("rst_busy", 32'(busy), 32'h0);
    check_eq("rst_gnt", 32'({a_gnt, b_gnt}), 32'h0);
    check_eq("rst_rvalid", 32'({a_rvalid, b_rvalid}), 32'h0);
    check_eq("rst_mem_en", 32'({mem_write_enable, mem_read_enable}), 32'h0);
    check_eq("rst_mem_addr", mem_addr, 32'h0);
    check_eq("rst_a_rdata", a_rdata, 32'h0);
    check_eq("rst_b_rdata", b_rdata, 32'h0);
    tb_init = 1'b0;
    reset   = 1'b1;

    // Round-robin tie straight out of reset: A first, then alternating.
    for (int i = 0; i < 8; i++) step(1, 0, 32'h1, 32'h0, 1, 0, 32'h2, 32'h0);

    // A writes 0xDEADBEEF to 0x10 then reads it back.
    step(1, 1, 32'h10, 32'hDEAD_BEEF, 0, 0, 32'h0, 32'h0);
    idle_steps(1);
    step(1, 0, 32'h10, 32'h0, 0, 0, 32'h0, 32'h0);
    idle_steps(2);
    check_eq("a_rdata_deadbeef", a_rdata, 32'hDEAD_BEEF);

    // B reads preloaded 0x05 while A writes 0x06.
    for (int i = 0; i < 4; i++) step(1, 1, 32'h6, 32'h0BAD_F00D, 1, 0, 32'h5, 32'h0);
    idle_steps(2);
    check_eq("b_rdata_preload", b_rdata, 32'h1E13_0000);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1, 32'($urandom_range(0, 15)),
           $urandom, $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
           32'($urandom_range(0, 15)), $urandom);
    end
    idle_steps(2);

    // Reset in the ACCESS cycle of a read aborts it.
    step(1, 0, 32'h5, 32'h0, 0, 0, 32'h0, 32'h0);
    #1 reset = 1'b0;
    #1;
    check_eq("abort_busy", 32'(busy), 32'h0);
    check_eq("abort_mem_re", 32'(mem_read_enable), 32'h0);
    check_eq("abort_gnt", 32'(a_gnt), 32'h0);
    check_eq("abort_rvalid", 32'({a_rvalid, b_rvalid}), 32'h0);
    #1 reset = 1'b1;
    model_reset();
    idle_steps(10);

    // First tie after reset again goes to A.
    step(1, 1, 32'h3, 32'h33, 1, 1, 32'h4, 32'h44);
    idle_steps(2);

    // Fixed-priority instance: A wins every tie, B only once A drops.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      fp_a_req = (i < 6);
      fp_b_req = 1'b1;
      @(posedge clk);
      #1;
      check_eq("fp_a_gnt", 32'(fp_a_gnt), 32'((i < 6) && (i % 2 == 0)));
      check_eq("fp_b_gnt", 32'(fp_b_gnt), 32'((i >= 6) && (i % 2 == 0)));
    end
    @(negedge clk);
    fp_a_req = 0;
    fp_b_req = 0;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
